// File: rtl/station_issue_queue_pkg.sv
// Shared types for the reservation station: operation names, per-entry storage
// and the issue register payload.
package station_issue_queue_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 6;

  typedef enum logic [2:0] {
    UNKNOWN = 3'd0,
    ADD     = 3'd1,
    SUB     = 3'd2,
    AND_OP  = 3'd3,
    OR_OP   = 3'd4,
    SLT     = 3'd5,
    LOAD    = 3'd6,
    STORE   = 3'd7
  } instr_name_e;

  typedef struct packed {
    logic              busy;
    instr_name_e       instr_name;
    logic [XLEN-1:0]   data_1;
    logic [XLEN-1:0]   data_2;
    logic [TAG_W-1:0]  tag_1;
    logic [TAG_W-1:0]  tag_2;
    logic              rdy_1;
    logic              rdy_2;
    logic [XLEN-1:0]   address;
    logic [XLEN-1:0]   immediate;
    logic [TAG_W-1:0]  rrn;
  } station_entry_t;

  typedef struct packed {
    instr_name_e       instr_name;
    logic [XLEN-1:0]   data_1;
    logic [XLEN-1:0]   data_2;
    logic [XLEN-1:0]   address;
    logic [XLEN-1:0]   immediate;
    logic [TAG_W-1:0]  rrn;
  } issue_t;

  function automatic logic tag_hit(input logic             valid,
                                   input logic [TAG_W-1:0] bus_tag,
                                   input logic [TAG_W-1:0] tag);
    return valid && (bus_tag == tag);
  endfunction

endpackage

// File: rtl/station_issue_queue_age_matrix.sv
// Age matrix: older_q[i][j]=1 means entry j was allocated before entry i.
// Picks the single oldest entry out of an eligible mask.
module station_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [DEPTH-1:0] alloc_oh_i,
  input  logic [DEPTH-1:0] free_oh_i,
  input  logic [DEPTH-1:0] busy_i,
  input  logic [DEPTH-1:0] elig_i,
  output logic [DEPTH-1:0] pick_oh_o
);

  logic [DEPTH-1:0] older_q [DEPTH];
  logic [DEPTH-1:0] older_d [DEPTH];

  // A new entry is younger than everything currently resident; freeing an
  // entry removes it from every row so it never blocks anyone again.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      older_d[i] = older_q[i];
      if (alloc_oh_i[i]) older_d[i] = busy_i;
      if (free_oh_i[i])  older_d[i] = '0;
      older_d[i] = older_d[i] & ~free_oh_i;
      if (flush)         older_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) older_q[i] <= older_d[i];
    end
  end

  always_comb begin
    pick_oh_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pick_oh_o[i] = elig_i[i] & ~(|(older_q[i] & elig_i));
    end
  end

endmodule

// File: rtl/station_issue_queue.sv
// Reservation station: buffers dispatched instructions, captures missing
// operands from the CDB and issues the oldest ready one through a register.
module station_issue_queue
  import station_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  instr_name_e                 in_instr_name,
  input  logic [XLEN-1:0]             in_data_1,
  input  logic [XLEN-1:0]             in_data_2,
  input  logic [TAG_W-1:0]            in_src_1_tag,
  input  logic [TAG_W-1:0]            in_src_2_tag,
  input  logic                        in_src_1_valid,
  input  logic                        in_src_2_valid,
  input  logic [XLEN-1:0]             in_address,
  input  logic [XLEN-1:0]             in_immediate,
  input  logic [TAG_W-1:0]            in_rrn,
  input  logic                        cdb_valid,
  input  logic [TAG_W-1:0]            cdb_tag,
  input  logic [XLEN-1:0]             cdb_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [XLEN-1:0]             out_data_1,
  output logic [XLEN-1:0]             out_data_2,
  output logic [XLEN-1:0]             out_address,
  output logic [XLEN-1:0]             out_immediate,
  output logic [TAG_W-1:0]            out_rrn,
  output instr_name_e                 out_instr_name,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int CNT_W = $clog2(DEPTH+1);

  station_entry_t   ent_q [DEPTH];
  station_entry_t   ent_d [DEPTH];
  station_entry_t   new_ent;
  issue_t           iss_q, iss_d, sel;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q;

  logic [DEPTH-1:0] busy, elig, alloc_oh, free_oh, pick_oh, wake_1, wake_2;
  logic             accept, load;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready depends only on registered count; out_valid never waits on out_ready.
  assign accept = in_valid & in_ready_q & ~flush;
  assign load   = (~out_valid_q | out_ready) & (|pick_oh) & ~flush;
  assign free_oh = pick_oh & {DEPTH{load}};

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    localparam logic [DEPTH-1:0] LOW_MASK = {DEPTH{1'b1}} >> (DEPTH - g);
    assign busy[g]     = ent_q[g].busy;
    assign elig[g]     = ent_q[g].busy & ent_q[g].rdy_1 & ent_q[g].rdy_2;
    // Lowest free slot: this one is free and every lower one is busy.
    assign alloc_oh[g] = accept & ~busy[g] & ((busy & LOW_MASK) == LOW_MASK);
    assign wake_1[g]   = busy[g] & ~ent_q[g].rdy_1 & tag_hit(cdb_valid, cdb_tag, ent_q[g].tag_1);
    assign wake_2[g]   = busy[g] & ~ent_q[g].rdy_2 & tag_hit(cdb_valid, cdb_tag, ent_q[g].tag_2);
  end

  station_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .alloc_oh_i (alloc_oh),
    .free_oh_i  (free_oh),
    .busy_i     (busy),
    .elig_i     (elig),
    .pick_oh_o  (pick_oh)
  );

  always_comb begin
    new_ent            = '0;
    new_ent.busy       = 1'b1;
    new_ent.instr_name = in_instr_name;
    new_ent.tag_1      = in_src_1_tag;
    new_ent.tag_2      = in_src_2_tag;
    new_ent.data_1     = in_data_1;
    new_ent.data_2     = in_data_2;
    new_ent.address    = in_address;
    new_ent.immediate  = in_immediate;
    new_ent.rrn        = in_rrn;
    if (in_src_1_valid) begin
      new_ent.rdy_1 = 1'b1;
    end else if (tag_hit(cdb_valid, cdb_tag, in_src_1_tag)) begin
      new_ent.rdy_1  = 1'b1;
      new_ent.data_1 = cdb_data;
    end
    if (in_src_2_valid) begin
      new_ent.rdy_2 = 1'b1;
    end else if (tag_hit(cdb_valid, cdb_tag, in_src_2_tag)) begin
      new_ent.rdy_2  = 1'b1;
      new_ent.data_2 = cdb_data;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (alloc_oh[i]) begin
        ent_d[i] = new_ent;
      end else begin
        if (wake_1[i]) begin
          ent_d[i].rdy_1  = 1'b1;
          ent_d[i].data_1 = cdb_data;
        end
        if (wake_2[i]) begin
          ent_d[i].rdy_2  = 1'b1;
          ent_d[i].data_2 = cdb_data;
        end
        if (free_oh[i]) ent_d[i].busy = 1'b0;
      end
      if (flush) ent_d[i].busy = 1'b0;
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pick_oh[i]) begin
        sel.instr_name = ent_q[i].instr_name;
        sel.data_1     = ent_q[i].data_1;
        sel.data_2     = ent_q[i].data_2;
        sel.address    = ent_q[i].address;
        sel.immediate  = ent_q[i].immediate;
        sel.rrn        = ent_q[i].rrn;
      end
    end
  end

  // The issue register is zeroed whenever it is empty so idle outputs are clean.
  always_comb begin
    out_valid_d = out_valid_q;
    iss_d       = iss_q;
    if (flush) begin
      out_valid_d = 1'b0;
      iss_d       = '0;
    end else if (load) begin
      out_valid_d = 1'b1;
      iss_d       = sel;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      iss_d       = '0;
    end
  end

  always_comb begin
    if (flush) count_d = '0;
    else       count_d = count_q + CNT_W'(accept) - CNT_W'(load);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      iss_q       <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      iss_q       <= iss_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
      in_ready_q  <= (count_d < CNT_W'(DEPTH));
    end
  end

  assign in_ready       = in_ready_q;
  assign count          = count_q;
  assign out_valid      = out_valid_q;
  assign out_instr_name = iss_q.instr_name;
  assign out_data_1     = iss_q.data_1;
  assign out_data_2     = iss_q.data_2;
  assign out_address    = iss_q.address;
  assign out_immediate  = iss_q.immediate;
  assign out_rrn        = iss_q.rrn;

endmodule

// File: tb/tb_station_issue_queue.sv
// Bench for station_issue_queue: vector table of single dispatches plus
// sequences for ordering, wakeup, full, flush and asynchronous reset.
module tb_station_issue_queue;
  import station_issue_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int W     = 3 + 4*XLEN + TAG_W;

  logic              clk = 1'b0;
  logic              reset_n, flush, in_valid, in_ready;
  instr_name_e       in_instr_name, out_instr_name;
  logic [XLEN-1:0]   in_data_1, in_data_2, in_address, in_immediate;
  logic [TAG_W-1:0]  in_src_1_tag, in_src_2_tag, in_rrn;
  logic              in_src_1_valid, in_src_2_valid;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [XLEN-1:0]   cdb_data;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   out_data_1, out_data_2, out_address, out_immediate;
  logic [TAG_W-1:0]  out_rrn;
  logic [CNT_W-1:0]  count;

  always #5 clk = ~clk;

  station_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr_name(in_instr_name),
    .in_data_1(in_data_1), .in_data_2(in_data_2),
    .in_src_1_tag(in_src_1_tag), .in_src_2_tag(in_src_2_tag),
    .in_src_1_valid(in_src_1_valid), .in_src_2_valid(in_src_2_valid),
    .in_address(in_address), .in_immediate(in_immediate), .in_rrn(in_rrn),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data_1(out_data_1), .out_data_2(out_data_2),
    .out_address(out_address), .out_immediate(out_immediate),
    .out_rrn(out_rrn), .out_instr_name(out_instr_name), .count(count)
  );

  typedef struct {
    instr_name_e      nm;
    logic             s1v;
    logic [TAG_W-1:0] t1;
    logic [XLEN-1:0]  d1;
    logic             s2v;
    logic [TAG_W-1:0] t2;
    logic [XLEN-1:0]  d2;
    logic             cv;
    logic [TAG_W-1:0] ct;
    logic [XLEN-1:0]  cd;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] rrn;
    logic [XLEN-1:0]  e1;
    logic [XLEN-1:0]  e2;
  } vec_t;

  vec_t          vecs [8];
  logic [W-1:0]  exp_q [$];
  int            tests = 0;
  int            fails = 0;

  function automatic logic [W-1:0] pack(input instr_name_e nm, input logic [XLEN-1:0] d1,
                                        input logic [XLEN-1:0] d2, input logic [XLEN-1:0] addr,
                                        input logic [XLEN-1:0] imm, input logic [TAG_W-1:0] rrn);
    return {nm, d1, d2, addr, imm, rrn};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every issue-port transfer must match the head of exp_q.
  task automatic mon_check();
    logic [W-1:0] got, exp;
    if (reset_n && out_valid && out_ready) begin
      got = pack(out_instr_name, out_data_1, out_data_2, out_address, out_immediate, out_rrn);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL issue_unexpected: got %0h expected nothing", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          fails++;
          $display("FAIL issue_data: got %0h expected %0h", got, exp);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_name_e nm, input logic s1v, input logic [TAG_W-1:0] t1,
                       input logic [XLEN-1:0] d1, input logic s2v, input logic [TAG_W-1:0] t2,
                       input logic [XLEN-1:0] d2, input logic [XLEN-1:0] addr,
                       input logic [XLEN-1:0] imm, input logic [TAG_W-1:0] rrn);
    in_valid = 1'b1; in_instr_name = nm;
    in_src_1_valid = s1v; in_src_1_tag = t1; in_data_1 = d1;
    in_src_2_valid = s2v; in_src_2_tag = t2; in_data_2 = d2;
    in_address = addr; in_immediate = imm; in_rrn = rrn;
  endtask

  task automatic cdb(input logic v, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] d);
    cdb_valid = v; cdb_tag = t; cdb_data = d;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_instr_name = UNKNOWN;
    in_src_1_valid = 1'b0; in_src_1_tag = '0; in_data_1 = '0;
    in_src_2_valid = 1'b0; in_src_2_tag = '0; in_data_2 = '0;
    in_address = '0; in_immediate = '0; in_rrn = '0;
    cdb(1'b0, 6'd0, 32'd0);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      step();
      c++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_valid"}, 64'(out_valid), 64'd0);
    check({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
    check({pfx, "_count"}, 64'(count), 64'd0);
    check({pfx, "_name"}, 64'(out_instr_name), 64'(UNKNOWN));
    check({pfx, "_d1"}, 64'(out_data_1), 64'd0);
    check({pfx, "_d2"}, 64'(out_data_2), 64'd0);
    check({pfx, "_addr"}, 64'(out_address), 64'd0);
    check({pfx, "_imm"}, 64'(out_immediate), 64'd0);
    check({pfx, "_rrn"}, 64'(out_rrn), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{ADD,    1'b1, 6'd0,  32'd5,        1'b1, 6'd0,  32'd7,        1'b0, 6'd0,  32'd0,
                32'h100, 32'h4, 6'd1, 32'd5, 32'd7};
    vecs[1] = '{SUB,    1'b0, 6'd3,  32'd0,        1'b1, 6'd0,  32'h10,       1'b1, 6'd3,  32'hAA,
                32'h200, 32'h8, 6'd2, 32'hAA, 32'h10};
    vecs[2] = '{SLT,    1'b1, 6'd0,  32'd1,        1'b0, 6'd7,  32'd0,        1'b1, 6'd7,  32'hBEEF,
                32'h300, 32'h0, 6'd3, 32'd1, 32'hBEEF};
    vecs[3] = '{AND_OP, 1'b0, 6'd12, 32'd0,        1'b0, 6'd12, 32'd0,        1'b1, 6'd12, 32'h55,
                32'h0, 32'hC, 6'd4, 32'h55, 32'h55};
    vecs[4] = '{OR_OP,  1'b1, 6'd9,  32'h77,       1'b1, 6'd0,  32'h3,        1'b1, 6'd9,  32'h99,
                32'h400, 32'h1, 6'd5, 32'h77, 32'h3};
    vecs[5] = '{LOAD,   1'b1, 6'd0,  32'hFFFFFFFF, 1'b1, 6'd0,  32'h0,        1'b0, 6'd0,  32'd0,
                32'hFFFFFFFC, 32'h80000000, 6'd63, 32'hFFFFFFFF, 32'h0};
    vecs[6] = '{STORE,  1'b0, 6'd63, 32'h5,        1'b1, 6'd0,  32'h12345678, 1'b1, 6'd63, 32'hDEADBEEF,
                32'h10, 32'h20, 6'd0, 32'hDEADBEEF, 32'h12345678};
    vecs[7] = '{ADD,    1'b1, 6'd2,  32'hA,        1'b1, 6'd2,  32'hB,        1'b1, 6'd2,  32'h999,
                32'h0, 32'h0, 6'd7, 32'hA, 32'hB};

    // clock/reset
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check_idle_outputs("rst0");

    // table of single dispatches, each drained before the next
    for (int i = 0; i < 8; i++) begin
      out_ready = 1'b1;
      drive(vecs[i].nm, vecs[i].s1v, vecs[i].t1, vecs[i].d1, vecs[i].s2v, vecs[i].t2,
            vecs[i].d2, vecs[i].addr, vecs[i].imm, vecs[i].rrn);
      cdb(vecs[i].cv, vecs[i].ct, vecs[i].cd);
      exp_q.push_back(pack(vecs[i].nm, vecs[i].e1, vecs[i].e2, vecs[i].addr, vecs[i].imm, vecs[i].rrn));
      step();
      idle();
      if (i == 0) begin
        check("lat_e0_valid", 64'(out_valid), 64'd0);
        check("lat_e0_count", 64'(count), 64'd1);
        step();
        check("lat_e1_valid", 64'(out_valid), 64'd1);
        check("lat_e1_d1", 64'(out_data_1), 64'd5);
        check("lat_e1_d2", 64'(out_data_2), 64'd7);
        check("lat_e1_rrn", 64'(out_rrn), 64'd1);
      end
      wait_drain($sformatf("vec%0d_drain", i), 10);
    end

    // ready younger B overtakes pending A; CDB wakes A
    out_ready = 1'b1;
    drive(SUB, 1'b1, 6'd0, 32'h11, 1'b0, 6'd9, 32'h0, 32'h500, 32'h5, 6'd10);
    step();
    drive(ADD, 1'b1, 6'd0, 32'h21, 1'b1, 6'd0, 32'h22, 32'h600, 32'h6, 6'd11);
    exp_q.push_back(pack(ADD, 32'h21, 32'h22, 32'h600, 32'h6, 6'd11));
    step();
    idle();
    repeat (3) step();
    check("ord_a_waiting_count", 64'(count), 64'd1);
    check("ord_a_waiting_valid", 64'(out_valid), 64'd0);
    exp_q.push_back(pack(SUB, 32'h11, 32'h1234, 32'h500, 32'h5, 6'd10));
    cdb(1'b1, 6'd9, 32'h1234);
    step();
    idle();
    check("wake_e0_valid", 64'(out_valid), 64'd0);
    step();
    check("wake_e1_valid", 64'(out_valid), 64'd1);
    check("wake_e1_d2", 64'(out_data_2), 64'h1234);
    wait_drain("ord_drain", 10);

    // back-to-back throughput
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(ADD, 1'b1, 6'd0, 32'(k + 32'h30), 1'b1, 6'd0, 32'(k), 32'd0, 32'd0, 6'(k + 20));
      exp_q.push_back(pack(ADD, 32'(k + 32'h30), 32'(k), 32'd0, 32'd0, 6'(k + 20)));
      step();
      if (k >= 1) check($sformatf("tput_valid%0d", k), 64'(out_valid), 64'd1);
    end
    idle();
    step();
    check("tput_valid4", 64'(out_valid), 64'd1);
    step();
    check("tput_empty", 64'(out_valid), 64'd0);
    wait_drain("tput_drain", 4);

    // fill to full with the issue port stalled
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(ADD, 1'b1, 6'd0, 32'(k + 32'h100), 1'b1, 6'd0, 32'(k), 32'd0, 32'd0, 6'(k));
      if (k < 9) exp_q.push_back(pack(ADD, 32'(k + 32'h100), 32'(k), 32'd0, 32'd0, 6'(k)));
      step();
    end
    idle();
    check("full_count", 64'(count), 64'd8);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_oldest", 64'(out_data_1), 64'h100);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pulse_count", 64'(count), 64'd7);
    check("pulse_in_ready", 64'(in_ready), 64'd1);
    check("pulse_next_oldest", 64'(out_data_1), 64'h101);
    drive(SUB, 1'b1, 6'd0, 32'h200, 1'b1, 6'd0, 32'h201, 32'd0, 32'd0, 6'd30);
    exp_q.push_back(pack(SUB, 32'h200, 32'h201, 32'd0, 32'd0, 6'd30));
    step();
    idle();
    out_ready = 1'b1;
    wait_drain("fill_drain", 40);

    // flush with dispatch and CDB in the same cycle
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(OR_OP, 1'b1, 6'd0, 32'(k), 1'b1, 6'd0, 32'(k), 32'd0, 32'd0, 6'(k));
      step();
    end
    drive(LOAD, 1'b0, 6'd12, 32'd0, 1'b1, 6'd0, 32'd1, 32'd0, 32'd0, 6'd40);
    step();
    check("pre_flush_count", 64'(count), 64'd6);
    check("pre_flush_valid", 64'(out_valid), 64'd1);
    drive(ADD, 1'b1, 6'd0, 32'h9, 1'b1, 6'd0, 32'h9, 32'd0, 32'd0, 6'd41);
    cdb(1'b1, 6'd12, 32'h77);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    check_idle_outputs("flush");
    out_ready = 1'b1;
    cdb(1'b1, 6'd12, 32'h77);
    step();
    idle();
    repeat (8) step();
    check("flush_quiet_valid", 64'(out_valid), 64'd0);
    check("flush_quiet_count", 64'(count), 64'd0);

    // asynchronous reset in the middle of a cycle
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(SLT, 1'b1, 6'd0, 32'(k + 32'h40), 1'b1, 6'd0, 32'h1, 32'h8, 32'h9, 6'(k + 50));
      step();
    end
    idle();
    step();
    check("mr_valid", 64'(out_valid), 64'd1);
    check("mr_count", 64'(count), 64'd3);
    #2 reset_n = 1'b0;
    #1;
    check_idle_outputs("mr");
    @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) step();
    check("mr_quiet_valid", 64'(out_valid), 64'd0);
    drive(STORE, 1'b1, 6'd0, 32'hCAFE, 1'b1, 6'd0, 32'hF00D, 32'h44, 32'h55, 6'd60);
    exp_q.push_back(pack(STORE, 32'hCAFE, 32'hF00D, 32'h44, 32'h55, 6'd60));
    step();
    idle();
    wait_drain("mr_after_drain", 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
